// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings and parity helper shared by the UART TX and RX paths
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   function automatic logic parity_calc(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with a registered head that holds its last value when empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [AW:0]      wp_q, wp_d, rp_q, rp_d, cnt;
   logic [AW-1:0]    nxt;
   logic             push_ok, pop_ok;

   assign empty   = wp_q == rp_q;
   assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign cnt     = wp_q - rp_q;
   assign nxt     = rp_q[AW-1:0] + 1'b1;
   assign rdata   = rdata_q;

   // pointer advance and head-register refresh (next entry, bypassed write, or hold)
   always_comb begin
      wp_d    = wp_q + {{AW{1'b0}}, push_ok};
      rp_d    = rp_q + {{AW{1'b0}}, pop_ok};
      rdata_d = pop_ok ? ((cnt != (AW+1)'(1)) ? mem_q[nxt] : (push_ok ? wdata : rdata_q))
                       : ((push_ok && empty) ? wdata : rdata_q);
   end

   // storage array, written without reset
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wp_q[AW-1:0]] <= wdata;
   end

   // pointers and head register
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         rdata_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART with programmable divisor, optional parity and sticky error flags
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int DIV_WIDTH  = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic [DATA_BITS-1:0] din,
   input  logic                 wr,
   output logic                 tx_full,
   output logic                 busy,
   output logic [DATA_BITS-1:0] dout,
   input  logic                 rd,
   output logic                 has_byte,
   output logic                 rx_full,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   input  logic                 clr_err,
   output logic                 TX,
   input  logic                 RX
);

   localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

   uart_state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_head;
   logic [3:0]           tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
   logic                 tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
   logic                 rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
   logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
   logic                 rx_s1_q, rx_s2_q;
   logic                 tx_empty, tx_pop, rx_empty, rx_push, set_fe, set_pe;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(wr & ~tx_full), .pop(tx_pop), .wdata(din),
      .rdata(tx_head), .full(tx_full), .empty(tx_empty)
   );

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rd), .wdata(rx_sh_q),
      .rdata(dout), .full(rx_full), .empty(rx_empty)
   );

   assign busy       = ~tx_empty | (tx_state_q != ST_IDLE);
   assign has_byte   = ~rx_empty;
   assign frame_err  = fe_q;
   assign parity_err = pe_q;
   assign overrun    = ov_q;
   assign TX = (tx_state_q == ST_START)  ? 1'b0 :
               (tx_state_q == ST_DATA)   ? tx_sh_q[0] :
               (tx_state_q == ST_PARITY) ? tx_par_q : 1'b1;

   // TX sequencing; a pop in IDLE or at STOP expiry starts the next frame with no gap
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_sh_d    = tx_sh_q;
      tx_idx_d   = tx_idx_q;
      tx_par_d   = tx_par_q;
      tx_pen_d   = tx_pen_q;
      tx_pop     = 1'b0;
      if (tx_state_q != ST_IDLE) tx_cnt_d = tx_cnt_q - 1'b1;
      case (tx_state_q)
         ST_IDLE:   tx_pop = ~tx_empty;
         ST_START:  if (tx_cnt_q == '0) begin
            tx_state_d = ST_DATA;
            tx_cnt_d   = tx_div_q;
            tx_idx_d   = '0;
         end
         ST_DATA:   if (tx_cnt_q == '0) begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_idx_d = tx_idx_q + 1'b1;
            tx_cnt_d = tx_div_q;
            if (tx_idx_q == LAST) tx_state_d = tx_pen_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: if (tx_cnt_q == '0) begin
            tx_state_d = ST_STOP;
            tx_cnt_d   = tx_div_q;
         end
         ST_STOP:   if (tx_cnt_q == '0) begin
            tx_state_d = ST_IDLE;
            tx_pop     = ~tx_empty;
         end
         default:   tx_state_d = ST_IDLE;
      endcase
      if (tx_pop) begin
         tx_state_d = ST_START;
         tx_cnt_d   = divisor;
         tx_div_d   = divisor;
         tx_sh_d    = tx_head;
         tx_par_d   = parity_calc(9'(tx_head), parity_odd);
         tx_pen_d   = parity_en;
      end
   end

   // RX sequencing; START expiry on a high line is treated as a glitch and discarded
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_div_d   = rx_div_q;
      rx_sh_d    = rx_sh_q;
      rx_idx_d   = rx_idx_q;
      rx_pen_d   = rx_pen_q;
      rx_odd_d   = rx_odd_q;
      rx_push    = 1'b0;
      set_fe     = 1'b0;
      set_pe     = 1'b0;
      if (rx_state_q != ST_IDLE) rx_cnt_d = rx_cnt_q - 1'b1;
      case (rx_state_q)
         ST_IDLE:   if (!rx_s2_q) begin
            rx_state_d = ST_START;
            rx_cnt_d   = divisor >> 1;
            rx_div_d   = divisor;
            rx_pen_d   = parity_en;
            rx_odd_d   = parity_odd;
         end
         ST_START:  if (rx_cnt_q == '0) begin
            rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
            rx_cnt_d   = rx_div_q;
            rx_idx_d   = '0;
         end
         ST_DATA:   if (rx_cnt_q == '0) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_idx_d = rx_idx_q + 1'b1;
            rx_cnt_d = rx_div_q;
            if (rx_idx_q == LAST) rx_state_d = rx_pen_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: if (rx_cnt_q == '0) begin
            set_pe     = rx_s2_q != parity_calc(9'(rx_sh_q), rx_odd_q);
            rx_state_d = ST_STOP;
            rx_cnt_d   = rx_div_q;
         end
         ST_STOP:   if (rx_cnt_q == '0) begin
            rx_push    = 1'b1;
            set_fe     = ~rx_s2_q;
            rx_state_d = ST_IDLE;
         end
         default:   rx_state_d = ST_IDLE;
      endcase
   end

   // sticky flags: a same-cycle set overrides clr_err; a pop alongside a full push avoids overrun
   always_comb begin
      fe_d = set_fe | (fe_q & ~clr_err);
      pe_d = set_pe | (pe_q & ~clr_err);
      ov_d = (rx_push & rx_full & ~rd) | (ov_q & ~clr_err);
   end

   // state registers, RX synchroniser and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= ST_IDLE;
         rx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= '0;
         rx_cnt_q   <= '0;
         rx_div_q   <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         tx_idx_q   <= '0;
         rx_idx_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_pen_q   <= 1'b0;
         rx_pen_q   <= 1'b0;
         rx_odd_q   <= 1'b0;
         fe_q       <= 1'b0;
         pe_q       <= 1'b0;
         ov_q       <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         tx_idx_q   <= tx_idx_d;
         rx_idx_q   <= rx_idx_d;
         tx_par_q   <= tx_par_d;
         tx_pen_q   <= tx_pen_d;
         rx_pen_q   <= rx_pen_d;
         rx_odd_q   <= rx_odd_d;
         fe_q       <= fe_d;
         pe_q       <= pe_d;
         ov_q       <= ov_d;
         rx_s1_q    <= RX;
         rx_s2_q    <= rx_s1_q;
      end
   end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: scenario tasks with scoreboard queues for uart_fifo
module tb_uart_fifo;

   localparam int DB = 8;
   localparam int DW = 12;
   localparam int FD = 4;

   logic          clk = 1'b0, rst = 1'b1;
   logic [DW-1:0] divisor = 12'd3;
   logic          parity_en = 1'b0, parity_odd = 1'b0;
   logic [DB-1:0] din = '0;
   logic          wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
   logic          rx_drv = 1'b1, loop = 1'b0;
   logic          tx_full, busy, has_byte, rx_full, frame_err, parity_err, overrun, tx_line, rx_line;
   logic [DB-1:0] dout;
   int            errors = 0, checks = 0;
   logic [DB-1:0] exp_q[$];

   assign rx_line = loop ? tx_line : rx_drv;

   always #5 clk = ~clk;

   uart_fifo #(.DATA_BITS(DB), .DIV_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .divisor(divisor), .parity_en(parity_en), .parity_odd(parity_odd),
      .din(din), .wr(wr), .tx_full(tx_full), .busy(busy), .dout(dout), .rd(rd),
      .has_byte(has_byte), .rx_full(rx_full), .frame_err(frame_err), .parity_err(parity_err),
      .overrun(overrun), .clr_err(clr_err), .TX(tx_line), .RX(rx_line)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         rx_drv = f[j];
         repeat (div + 1) tick();
      end
      rx_drv = 1'b1;
      repeat (4) tick();
   endtask

   task automatic tx_stream(input int n, input int div, input logic pen, input logic odd);
      logic [7:0]  b;
      logic [10:0] f;
      int          nb, t;
      t = 0;
      while (tx_line !== 1'b0 && t < 300) begin
         tick();
         t++;
      end
      checks++;
      if (tx_line !== 1'b0) begin
         errors++;
         $display("FAIL tx_start_wait: TX=%b expected 0 within 300 clks", tx_line);
         return;
      end
      for (int i = 0; i < n; i++) begin
         b  = exp_q.pop_front();
         f  = pen ? {1'b1, (^b) ^ odd, b, 1'b0} : {2'b11, b, 1'b0};
         nb = pen ? 11 : 10;
         for (int j = 0; j < nb; j++) begin
            for (int k = 0; k <= div; k++) begin
               if (i != 0 || j != 0 || k != 0) tick();
               checks++;
               if (tx_line !== f[j]) begin
                  errors++;
                  $display("FAIL tx_bit byte%0d=%h bit%0d clk%0d: TX=%b expected %b", i, b, j, k, tx_line, f[j]);
               end
            end
         end
      end
      tick();
      checks++;
      if (tx_line !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tx_idle_after: TX=%b busy=%b expected TX=1 busy=0", tx_line, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({tx_line, busy, tx_full, has_byte, rx_full} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: TX,busy,tx_full,has_byte,rx_full=%b expected 10000",
                  {tx_line, busy, tx_full, has_byte, rx_full});
      end
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_dout: dout=%h expected 00", dout);
      end
      checks++;
      if ({frame_err, parity_err, overrun} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: fe,pe,ov=%b expected 000", {frame_err, parity_err, overrun});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_tx_frame();
      logic       lv_q[$];
      logic [9:0] pat;
      logic       lv;
      int         busy_cnt;
      pat = 10'b11_0100_1010;
      for (int j = 0; j < 10; j++) repeat (4) lv_q.push_back(pat[j]);
      divisor = 12'd3;
      din = 8'hA5;
      wr = 1'b1;
      tick();
      wr = 1'b0;
      checks++;
      if (busy !== 1'b1 || tx_line !== 1'b1) begin
         errors++;
         $display("FAIL tx_latency: busy=%b TX=%b expected busy=1 TX=1", busy, tx_line);
      end
      busy_cnt = busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         lv = lv_q.pop_front();
         busy_cnt += busy ? 1 : 0;
         checks++;
         if (tx_line !== lv) begin
            errors++;
            $display("FAIL tx_a5 clk%0d: TX=%b expected %b", i, tx_line, lv);
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0 || tx_line !== 1'b1) begin
         errors++;
         $display("FAIL tx_a5_end: busy=%b TX=%b expected 0 1", busy, tx_line);
      end
      checks++;
      if (busy_cnt != 41) begin
         errors++;
         $display("FAIL tx_busy_len: busy high %0d clks expected 41", busy_cnt);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] d [3];
      logic [7:0] e;
      int         t;
      d = '{8'h00, 8'hFF, 8'h3C};
      exp_q.delete();
      divisor = 12'd3;
      parity_en = 1'b1;
      parity_odd = 1'b1;
      loop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = d[i];
         wr = 1'b1;
         exp_q.push_back(d[i]);
         tick();
      end
      wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         t = 0;
         while (has_byte !== 1'b1 && t < 300) begin
            tick();
            t++;
         end
         e = exp_q.pop_front();
         checks++;
         if (has_byte !== 1'b1 || dout !== e) begin
            errors++;
            $display("FAIL loop_byte%0d: has_byte=%b dout=%h expected 1 %h", i, has_byte, dout, e);
         end
         rd = 1'b1;
         tick();
         rd = 1'b0;
      end
      repeat (20) tick();
      checks++;
      if ({parity_err, frame_err, has_byte, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL loop_end: pe,fe,has_byte,busy=%b expected 0000", {parity_err, frame_err, has_byte, busy});
      end
      loop = 1'b0;
      parity_en = 1'b0;
      parity_odd = 1'b0;
      tick();
   endtask

   task automatic test_tx_fifo_full();
      logic [7:0] d [6];
      d = '{8'hC3, 8'h01, 8'h80, 8'h7E, 8'h99, 8'hEE};
      exp_q.delete();
      divisor = 12'd3;
      exp_q.push_back(d[0]);
      fork
         begin
            din = d[0];
            wr = 1'b1;
            tick();
            wr = 1'b0;
            repeat (3) tick();
            for (int i = 1; i < 6; i++) begin
               if (i < 5) exp_q.push_back(d[i]);
               din = d[i];
               wr = 1'b1;
               tick();
               checks++;
               if (tx_full !== (i >= 4)) begin
                  errors++;
                  $display("FAIL tx_full_wr%0d: tx_full=%b expected %b", i, tx_full, i >= 4);
               end
            end
            wr = 1'b0;
         end
         tx_stream(5, 3, 1'b0, 1'b0);
      join
   endtask

   task automatic test_rx_overrun();
      logic [7:0] d [5];
      logic [7:0] e;
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      exp_q.delete();
      divisor = 12'd3;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(d[i]);
         send_rx(d[i], 1'b1, 3);
         if (i == 3) begin
            checks++;
            if (rx_full !== 1'b1 || overrun !== 1'b0) begin
               errors++;
               $display("FAIL rx_full4: rx_full=%b overrun=%b expected 1 0", rx_full, overrun);
            end
         end
      end
      checks++;
      if ({has_byte, rx_full, overrun} !== 3'b111 || dout !== 8'h11) begin
         errors++;
         $display("FAIL rx_overrun: hb,full,ov=%b dout=%h expected 111 11", {has_byte, rx_full, overrun}, dout);
      end
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (dout !== e || has_byte !== 1'b1) begin
            errors++;
            $display("FAIL rx_read%0d: dout=%h has_byte=%b expected %h 1", i, dout, has_byte, e);
         end
         rd = 1'b1;
         tick();
         rd = 1'b0;
      end
      checks++;
      if (has_byte !== 1'b0 || dout !== 8'h44) begin
         errors++;
         $display("FAIL rx_drained: has_byte=%b dout=%h expected 0 44", has_byte, dout);
      end
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++;
      if (has_byte !== 1'b0 || dout !== 8'h44) begin
         errors++;
         $display("FAIL rx_rd_empty: has_byte=%b dout=%h expected 0 44", has_byte, dout);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL clr_overrun: overrun=%b expected 0", overrun);
      end
   endtask

   task automatic test_frame_err_glitch();
      logic [7:0] e;
      exp_q.delete();
      divisor = 12'd3;
      exp_q.push_back(8'h55);
      send_rx(8'h55, 1'b0, 3);
      e = exp_q.pop_front();
      checks++;
      if (has_byte !== 1'b1 || dout !== e || {frame_err, parity_err, overrun} !== 3'b100) begin
         errors++;
         $display("FAIL frame_err: hb=%b dout=%h fe,pe,ov=%b expected 1 %h 100",
                  has_byte, dout, {frame_err, parity_err, overrun}, e);
      end
      rd = 1'b1;
      clr_err = 1'b1;
      tick();
      rd = 1'b0;
      clr_err = 1'b0;
      checks++;
      if (has_byte !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_clr: has_byte=%b fe=%b expected 0 0", has_byte, frame_err);
      end
      divisor = 12'd7;
      rx_drv = 1'b0;
      tick();
      rx_drv = 1'b1;
      repeat (40) tick();
      checks++;
      if ({has_byte, frame_err, parity_err, overrun} !== 4'b0000) begin
         errors++;
         $display("FAIL glitch: hb,fe,pe,ov=%b expected 0000", {has_byte, frame_err, parity_err, overrun});
      end
   endtask

   task automatic test_reset_midframe();
      int t;
      exp_q.delete();
      divisor = 12'd3;
      send_rx(8'h5A, 1'b1, 3);
      checks++;
      if (has_byte !== 1'b1 || dout !== 8'h5A) begin
         errors++;
         $display("FAIL pre_rst_rx: has_byte=%b dout=%h expected 1 5a", has_byte, dout);
      end
      din = 8'h81;
      wr = 1'b1;
      tick();
      din = 8'h42;
      tick();
      wr = 1'b0;
      t = 0;
      while (tx_line !== 1'b0 && t < 50) begin
         tick();
         t++;
      end
      repeat (16) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({tx_line, busy, tx_full, has_byte, rx_full} !== 5'b10000 || dout !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid: TX,busy,txf,hb,rxf=%b dout=%h expected 10000 00",
                  {tx_line, busy, tx_full, has_byte, rx_full}, dout);
      end
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (busy !== 1'b0 || tx_line !== 1'b1) begin
         errors++;
         $display("FAIL rst_fifo_empty: busy=%b TX=%b expected 0 1", busy, tx_line);
      end
      exp_q.push_back(8'h81);
      din = 8'h81;
      wr = 1'b1;
      tick();
      wr = 1'b0;
      tx_stream(1, 3, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_loopback();
      test_tx_fifo_full();
      test_rx_overrun();
      test_frame_err_glitch();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time=%0t expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Parametrised successor to the single-byte UART used in the AS1802 CPLD peripheral set. It adds:
- Runtime-programmable baud divisor, latched per frame.
- Configurable data width and optional even/odd parity.
- Independent TX and RX FIFOs.
- Sticky error flags: framing, parity, overrun.
- Mid-bit RX sampling with a synchronised input and glitch rejection on the start bit.

It sits behind the CPU I/O decoder. `wr` and `rd` are single-cycle strobes generated from the memory-write and memory-read decode.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
DIV_WIDTH, 12, width of divisor input; bit period = divisor+1 clocks
FIFO_DEPTH, 4, entries per FIFO; power of two, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
divisor  in  DIV_WIDTH  bit period minus one; must be >=3
parity_en  in  1  1 = parity bit inserted/checked after data
parity_odd  in  1  1 = odd parity, 0 = even
din  in  DATA_BITS  TX data
wr  in  1  push din into TX FIFO
tx_full  out  1  TX FIFO full
busy  out  1  TX FIFO non-empty or frame in flight
dout  out  DATA_BITS  head of RX FIFO (show-ahead)
rd  in  1  pop RX FIFO
has_byte  out  1  RX FIFO non-empty
rx_full  out  1  RX FIFO full
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: byte received while RX FIFO full
clr_err  in  1  clear all three sticky flags
TX  out  1  serial out, idle high
RX  in  1  serial in, asynchronous

Behaviour:
Reset (`rst` sampled high at a clk edge):
- Takes effect next cycle: TX=1, busy=0, tx_full=0, has_byte=0, rx_full=0, dout=0, all error flags 0.
- Both FIFOs are emptied. Any frame in progress on either side is aborted.

Divisor latching:
- `divisor` is latched at frame start, independently for TX and RX.
- A change mid-frame affects only the next frame.

TX FIFO:
- `wr` with tx_full=1 is ignored; din is dropped.

TX FSM (IDLE -> START -> DATA -> PARITY (if parity_en) -> STOP -> IDLE):
- In IDLE with the FIFO non-empty, pop the head and drive TX=0 on the next cycle.
- Each state holds for divisor+1 clocks. Data is sent LSB first.
- Parity bit = XOR(data) ^ parity_odd.
- Back-to-back frames: the next START follows STOP with no idle gap.
- busy is asserted the cycle after the first accepted wr. It drops in the cycle after STOP completes with the FIFO empty.

RX input synchronisation:
- RX passes through a 2-flop synchroniser (2-cycle latency). All sampling uses the synchronised value.

RX FSM (IDLE -> START -> DATA -> PARITY (if parity_en) -> STOP -> IDLE):
- IDLE: a low level starts START and loads the counter with divisor>>1.
- START: at counter expiry (mid start bit), if the line is high, return to IDLE (glitch, nothing recorded). Otherwise sample each later bit every divisor+1 clocks.
- PARITY: on mismatch, set parity_err.
- STOP: a low sample sets frame_err; the byte is still pushed. RX returns to IDLE at the stop mid-point.
- Push with rx_full=1: byte dropped, overrun set, FIFO contents unchanged.
- Simultaneous rd and push on a full FIFO: pop and push both succeed; overrun is not set.

RX FIFO:
- `rd` with has_byte=0 is ignored.
- dout always shows the head entry. It updates the cycle after a pop or after a push into an empty FIFO. Its value is unchanged when the FIFO is empty.

Error flags:
- clr_err together with a same-cycle error event: the set wins.

FIFO pointers:
- log2(FIFO_DEPTH)+1 bits, wrapping naturally.
- Full = MSBs differ and the rest are equal; empty = pointers equal.

Decomposition:
- Package uart_pkg: state encodings (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP) shared by the TX and RX FSMs.
- Package uart_pkg: function parity_calc(data, odd).
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, push, pop, wdata, rdata, full, empty), instantiated twice.

Test Plan:
- divisor=3, no parity; wr 0xA5 → TX low 4 clks, then 1,0,1,0,0,1,0,1 each 4 clks, then high 4 clks; busy high for exactly 40 clks plus a 1-clk latency.
- Loopback TX→RX, divisor=3, parity_en=1, parity_odd=1; send 0x00, 0xFF, 0x3C → has_byte rises; dout reads 0x00, 0xFF, 0x3C in order; parity_err=0.
- 5 writes at FIFO_DEPTH=4 while first frame in flight → tx_full after 4th accepted entry; 5th byte never transmitted; all 4 accepted bytes sent back-to-back with no gaps.
- Drive 5 frames into RX without rd → has_byte=1, rx_full=1, overrun=1; dout=first byte; 5th byte lost; clr_err clears overrun.
- Stop bit forced low on 0x55 → byte 0x55 pushed, frame_err=1. RX low pulse of 1 clk at divisor=7 → no byte, no flags.
- rst asserted mid-frame after 3 data bits → next cycle TX=1, busy=0, FIFOs empty; new wr 0x81 transmits a complete clean frame.
